sdr_req_split: RTL and testbench

- Request generator stage of the SDRAM controller. Sits between the application port and transfer control.
- Accepts one application burst request (address, length, direction) and splits it into page-bounded bank requests for the downstream transfer-control stage.
- Exports its 2-bit FSM state `req_st` so the coverage interface can sample it directly.

---
 rtl/sdr_req_pkg.sv | 32 +++
 rtl/sdr_addr_map.sv | 32 +++
 rtl/sdr_req_split.sv | 169 ++++++++++++++++
 tb/tb_sdr_req_split.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sdr_req_pkg.sv
// Shared types, address-field offsets and chunk sizing for the SDRAM request generator.
package sdr_req_pkg;

  // Default geometry of the SDRAM address map.
  localparam int SDR_COL_W  = 8;
  localparam int SDR_BANK_W = 2;
  localparam int SDR_ROW_W  = 12;
  localparam int SDR_LEN_W  = 8;

  // Field offsets inside a {row, bank, col} word address, with col at the LSBs.
  localparam int COL_LSB  = 0;
  localparam int BANK_LSB = SDR_COL_W;
  localparam int ROW_LSB  = SDR_COL_W + SDR_BANK_W;

  // Request-generator state; the encoding is exported for coverage sampling.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    ISSUE = 2'd2
  } req_st_e;

  // Words that can be issued before hitting the end of the current page:
  // min(remaining, 2^col_w - col).
  function automatic int unsigned chunk_len(input int unsigned remaining,
                                            input int unsigned col,
                                            input int unsigned col_w);
    int unsigned room;
    room = (32'd1 << col_w) - col;
    return (remaining < room) ? remaining : room;
  endfunction

endpackage

// File: rtl/sdr_addr_map.sv
// Field slicing of a {row, bank, col} word address and the address-advance adder.
// A column carry ripples into the bank, a bank carry into the row, and the
// all-ones address wraps to zero.
module sdr_addr_map
  import sdr_req_pkg::*;
#(
  parameter int COL_W  = SDR_COL_W,
  parameter int BANK_W = SDR_BANK_W,
  parameter int ROW_W  = SDR_ROW_W,
  parameter int LEN_W  = SDR_LEN_W,
  parameter int C_LSB  = COL_LSB,
  parameter int B_LSB  = BANK_LSB,
  parameter int R_LSB  = ROW_LSB,
  localparam int APP_AW = ROW_W + BANK_W + COL_W
) (
  input  logic [APP_AW-1:0] addr_i,
  input  logic [LEN_W-1:0]  inc_i,
  output logic [ROW_W-1:0]  row_o,
  output logic [BANK_W-1:0] bank_o,
  output logic [COL_W-1:0]  col_o,
  output logic [APP_AW-1:0] addr_next_o
);

  assign col_o  = addr_i[C_LSB +: COL_W];
  assign bank_o = addr_i[B_LSB +: BANK_W];
  assign row_o  = addr_i[R_LSB +: ROW_W];

  // Plain binary add over the packed address gives the col->bank->row carry
  // chain, and truncation to APP_AW bits provides the wrap.
  assign addr_next_o = addr_i + APP_AW'(inc_i);

endmodule

// File: rtl/sdr_req_split.sv
// SDRAM request generator: accepts one application burst and splits it into
// page-bounded bank requests for transfer control. All outputs are registered.
module sdr_req_split
  import sdr_req_pkg::*;
#(
  parameter int COL_W  = SDR_COL_W,
  parameter int BANK_W = SDR_BANK_W,
  parameter int ROW_W  = SDR_ROW_W,
  parameter int LEN_W  = SDR_LEN_W,
  localparam int APP_AW = ROW_W + BANK_W + COL_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              app_req,
  input  logic [APP_AW-1:0] app_req_addr,
  input  logic [LEN_W-1:0]  app_req_len,
  input  logic              app_req_wr_n,
  output logic              app_req_ack,
  output logic              r2b_req,
  output logic [BANK_W-1:0] r2b_ba,
  output logic [ROW_W-1:0]  r2b_raddr,
  output logic [COL_W-1:0]  r2b_caddr,
  output logic [LEN_W-1:0]  r2b_len,
  output logic              r2b_write,
  output logic              r2b_last,
  input  logic              b2r_ack,
  output logic [1:0]        req_st
);

  req_st_e             state_q, state_d;
  logic [APP_AW-1:0]   addr_q, addr_d;      // address of the next chunk
  logic [LEN_W-1:0]    rem_q, rem_d;        // words still to be issued
  logic                wr_q, wr_d;          // direction of the accepted burst
  logic                ack_q, ack_d;
  logic                req_q, req_d;
  logic [BANK_W-1:0]   ba_q, ba_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                write_q, write_d;
  logic                last_q, last_d;

  logic [ROW_W-1:0]    map_row;
  logic [BANK_W-1:0]   map_bank;
  logic [COL_W-1:0]    map_col;
  logic [APP_AW-1:0]   addr_adv;
  logic [LEN_W-1:0]    chunk;

  // The advance adder always steps by the chunk currently on the bank port.
  sdr_addr_map #(
    .COL_W  (COL_W),
    .BANK_W (BANK_W),
    .ROW_W  (ROW_W),
    .LEN_W  (LEN_W),
    .C_LSB  (0),
    .B_LSB  (COL_W),
    .R_LSB  (COL_W + BANK_W)
  ) u_addr_map (
    .addr_i      (addr_q),
    .inc_i       (len_q),
    .row_o       (map_row),
    .bank_o      (map_bank),
    .col_o       (map_col),
    .addr_next_o (addr_adv)
  );

  // Chunk never exceeds the remaining length, so it always fits in LEN_W.
  assign chunk = LEN_W'(chunk_len(32'(rem_q), 32'(map_col), COL_W));

  // Next-state and output decode; everything defaults to holding its value,
  // except the accept pulse which defaults low.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wr_d    = wr_q;
    ack_d   = 1'b0;
    req_d   = req_q;
    ba_d    = ba_q;
    row_d   = row_q;
    col_d   = col_q;
    len_d   = len_q;
    write_d = write_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (app_req) begin
          ack_d = 1'b1;
          // A zero-length request is acknowledged but produces no chunks.
          if (app_req_len != '0) begin
            addr_d  = app_req_addr;
            rem_d   = app_req_len;
            wr_d    = ~app_req_wr_n;
            state_d = SPLIT;
          end
        end
      end

      SPLIT: begin
        ba_d    = map_bank;
        row_d   = map_row;
        col_d   = map_col;
        len_d   = chunk;
        write_d = wr_q;
        last_d  = (chunk == rem_q);
        req_d   = 1'b1;
        state_d = ISSUE;
      end

      ISSUE: begin
        // Bank port is held untouched until transfer control takes the chunk.
        if (b2r_ack && req_q) begin
          rem_d   = rem_q - len_q;
          addr_d  = addr_adv;
          req_d   = 1'b0;
          state_d = last_q ? IDLE : SPLIT;
        end
      end

      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any burst in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      len_q   <= '0;
      write_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      ba_q    <= ba_d;
      row_q   <= row_d;
      col_q   <= col_d;
      len_q   <= len_d;
      write_q <= write_d;
      last_q  <= last_d;
    end
  end

  assign app_req_ack = ack_q;
  assign r2b_req     = req_q;
  assign r2b_ba      = ba_q;
  assign r2b_raddr   = row_q;
  assign r2b_caddr   = col_q;
  assign r2b_len     = len_q;
  assign r2b_write   = write_q;
  assign r2b_last    = last_q;
  assign req_st      = state_q;

endmodule

// File: tb/tb_sdr_req_split.sv
// Directed bench for sdr_req_split: single chunk, page/bank/row carries,
// top-of-memory wrap, backpressure, coincident request, zero length, reset.
module tb_sdr_req_split;

  localparam int COL_W  = 8;
  localparam int BANK_W = 2;
  localparam int ROW_W  = 12;
  localparam int LEN_W  = 8;
  localparam int APP_AW = ROW_W + BANK_W + COL_W;

  logic              clk;
  logic              reset_n;
  logic              app_req;
  logic [APP_AW-1:0] app_req_addr;
  logic [LEN_W-1:0]  app_req_len;
  logic              app_req_wr_n;
  logic              app_req_ack;
  logic              r2b_req;
  logic [BANK_W-1:0] r2b_ba;
  logic [ROW_W-1:0]  r2b_raddr;
  logic [COL_W-1:0]  r2b_caddr;
  logic [LEN_W-1:0]  r2b_len;
  logic              r2b_write;
  logic              r2b_last;
  logic              b2r_ack;
  logic [1:0]        req_st;

  int n_checks = 0;
  int n_fail   = 0;

  sdr_req_split dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .app_req      (app_req),
    .app_req_addr (app_req_addr),
    .app_req_len  (app_req_len),
    .app_req_wr_n (app_req_wr_n),
    .app_req_ack  (app_req_ack),
    .r2b_req      (r2b_req),
    .r2b_ba       (r2b_ba),
    .r2b_raddr    (r2b_raddr),
    .r2b_caddr    (r2b_caddr),
    .r2b_len      (r2b_len),
    .r2b_write    (r2b_write),
    .r2b_last     (r2b_last),
    .b2r_ack      (b2r_ack),
    .req_st       (req_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All outputs packed together, for the reset checks.
  function automatic logic [63:0] all_outs();
    return 64'({app_req_ack, r2b_req, r2b_ba, r2b_raddr, r2b_caddr,
                r2b_len, r2b_write, r2b_last, req_st});
  endfunction

  // Present a request, then check the accept pulse and its one-cycle width.
  task automatic start_req(input string tag, input logic [APP_AW-1:0] addr,
                           input logic [LEN_W-1:0] len, input logic wr_n);
    app_req_addr = addr;
    app_req_len  = len;
    app_req_wr_n = wr_n;
    app_req      = 1'b1;
    @(negedge clk);
    app_req = 1'b0;
    chk({tag, " ack"}, 64'({app_req_ack, r2b_req, req_st}),
        64'({1'b1, 1'b0, (len != '0) ? 2'd1 : 2'd0}));
    @(negedge clk);
    chk({tag, " ack pulse"}, 64'(app_req_ack), 64'd0);
  endtask

  // Check the chunk presented on the bank port.
  task automatic chk_chunk(input string tag, input logic [BANK_W-1:0] ba,
                           input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                           input logic [LEN_W-1:0] len, input logic wr, input logic last);
    $display("chunk %s: ba=%0d row=0x%0h col=0x%0h len=%0d wr=%0d last=%0d",
             tag, r2b_ba, r2b_raddr, r2b_caddr, r2b_len, r2b_write, r2b_last);
    chk({tag, " req"}, 64'({r2b_req, req_st}), 64'({1'b1, 2'd2}));
    chk({tag, " fields"},
        64'({r2b_ba, r2b_raddr, r2b_caddr, r2b_len, r2b_write, r2b_last}),
        64'({ba, row, col, len, wr, last}));
  endtask

  // Acknowledge the current chunk; for a non-final chunk, step over the
  // single SPLIT cycle so the next chunk is on the port on return.
  task automatic accept_chunk(input string tag, input logic last);
    b2r_ack = 1'b1;
    @(negedge clk);
    b2r_ack = 1'b0;
    chk({tag, " drop"}, 64'({r2b_req, req_st}),
        64'({1'b0, last ? 2'd0 : 2'd1}));
    if (!last) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n      = 1'b1;
    app_req      = 1'b0;
    app_req_addr = '0;
    app_req_len  = '0;
    app_req_wr_n = 1'b1;
    b2r_ack      = 1'b0;

    // Reset state.
    #1 reset_n = 1'b0;
    #1 chk("reset outputs", all_outs(), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", 64'({app_req_ack, r2b_req, req_st}), 64'd0);

    // Single chunk, read.
    start_req("single", {12'd5, 2'd1, 8'h10}, 8'd4, 1'b1);
    chk_chunk("single c1", 2'd1, 12'd5, 8'h10, 8'd4, 1'b0, 1'b1);
    accept_chunk("single c1", 1'b1);

    // Page cross into the next bank, write.
    start_req("pagex", {12'd7, 2'd2, 8'hFC}, 8'd10, 1'b0);
    chk_chunk("pagex c1", 2'd2, 12'd7, 8'hFC, 8'd4, 1'b1, 1'b0);
    accept_chunk("pagex c1", 1'b0);
    chk_chunk("pagex c2", 2'd3, 12'd7, 8'h00, 8'd6, 1'b1, 1'b1);
    accept_chunk("pagex c2", 1'b1);

    // Bank carry into the row; final ack coincides with a new app_req.
    start_req("rowc", {12'd5, 2'd3, 8'hFE}, 8'd4, 1'b1);
    chk_chunk("rowc c1", 2'd3, 12'd5, 8'hFE, 8'd2, 1'b0, 1'b0);
    accept_chunk("rowc c1", 1'b0);
    chk_chunk("rowc c2", 2'd0, 12'd6, 8'h00, 8'd2, 1'b0, 1'b1);
    app_req_addr = {12'd9, 2'd0, 8'h00};
    app_req_len  = 8'd1;
    app_req_wr_n = 1'b1;
    app_req      = 1'b1;
    b2r_ack      = 1'b1;
    @(negedge clk);
    b2r_ack = 1'b0;
    chk("coinc no ack", 64'({app_req_ack, r2b_req, req_st}), 64'({1'b0, 1'b0, 2'd0}));
    @(negedge clk);
    app_req = 1'b0;
    chk("coinc ack", 64'({app_req_ack, r2b_req, req_st}), 64'({1'b1, 1'b0, 2'd1}));
    @(negedge clk);
    chk_chunk("coinc c1", 2'd0, 12'd9, 8'h00, 8'd1, 1'b0, 1'b1);
    accept_chunk("coinc c1", 1'b1);

    // All-ones address wraps to zero.
    start_req("wrap", {12'hFFF, 2'd3, 8'hFF}, 8'd3, 1'b1);
    chk_chunk("wrap c1", 2'd3, 12'hFFF, 8'hFF, 8'd1, 1'b0, 1'b0);
    accept_chunk("wrap c1", 1'b0);
    chk_chunk("wrap c2", 2'd0, 12'd0, 8'h00, 8'd2, 1'b0, 1'b1);
    accept_chunk("wrap c2", 1'b1);

    // Backpressure with app_req pulsing while busy.
    start_req("bp", {12'd20, 2'd0, 8'h00}, 8'd8, 1'b0);
    chk_chunk("bp c1", 2'd0, 12'd20, 8'h00, 8'd8, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      app_req = (i % 2 == 0);
      @(negedge clk);
      chk_chunk("bp hold", 2'd0, 12'd20, 8'h00, 8'd8, 1'b1, 1'b1);
      chk("bp no ack", 64'(app_req_ack), 64'd0);
    end
    app_req = 1'b0;
    accept_chunk("bp c1", 1'b1);

    // Zero length: ack only, no bank request.
    start_req("zero", {12'd1, 2'd1, 8'h01}, 8'd0, 1'b1);
    @(negedge clk);
    chk("zero no req", 64'({r2b_req, req_st}), 64'd0);

    // Reset while a chunk is waiting in ISSUE.
    start_req("rst", {12'd3, 2'd1, 8'h00}, 8'd50, 1'b1);
    chk_chunk("rst c1", 2'd1, 12'd3, 8'h00, 8'd50, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk("reset in issue", all_outs(), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle after reset 2", 64'({app_req_ack, r2b_req, req_st}), 64'd0);

    // Normal operation after reset: half-page start, 200 words.
    start_req("post", {12'd1, 2'd2, 8'h80}, 8'd200, 1'b0);
    chk_chunk("post c1", 2'd2, 12'd1, 8'h80, 8'd128, 1'b1, 1'b0);
    accept_chunk("post c1", 1'b0);
    chk_chunk("post c2", 2'd3, 12'd1, 8'h00, 8'd72, 1'b1, 1'b1);
    accept_chunk("post c2", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
